reparameterization_sampler: RTL and testbench
=============================================

# reparameterization_sampler

Produces the 2-entry latent vector z = mu + exp(0.5*logvar)*eps that the VAE decoder reads. It sits between the encoder's output buffer and the decoder's parametric-read port and is the write/serve side of the `Reparam_output_address`/`Parametric_data`/`EnableReadParametric` interface. It fetches mu and logvar from the encoder, computes z in Q10.10, stores it, and then serves registered reads to the decoder.

## Interface
- `LATENT`, 2: number of latent elements. Fixed to 2; other values are unsupported.
- `integer_width`, 10: integer bits of the signed fixed-point format.
- `fraction_width`, 10: fraction bits. Data width W = 20.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Used only with the macro described in Configuration.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Encoder_done` in 1: level signal; its rising edge starts a run.
- `Encoder_output_address` out 2: encoder read address. 0/1 select mu0/mu1; 2/3 select logvar0/logvar1.
- `Encoder_output_data` in 20: signed Q10.10. It is valid one cycle after the address.
- `Reparam_output_address` in 2: decoder read address.
- `Parametric_data` out 20: registered read data. `Parametric_data` <= z[addr] when addr < 2, otherwise 0.
- `EnableReadParametric` out 1: high when z is valid.

## Operation
- States are IDLE, FETCH, COMPUTE and DONE.
- IDLE → FETCH on a rising edge of `Encoder_done`, detected against a registered previous value.
- FETCH:
  - Drive addresses 0,1,2,3 on consecutive cycles.
  - Capture the data of each address one cycle later into mu[0..1] and lv[0..1].
  - Go to COMPUTE after the 4th capture.
- COMPUTE takes 2 cycles per latent element i.
  - Cycle A:
    - y = lv[i]>>>1.
    - t = (y*1477)>>>10, where 1477 is log2(e) in Q10.10.
    - k = t>>>10, clamped to [-10,9].
    - f = t[9:0].
    - sigma = (1024+f) shifted left by k, or right by -k (Mitchell approximation of 2^t).
  - Cycle B:
    - p = (sigma*eps)>>>10, full 40-bit product.
    - s = mu[i]+p.
    - Saturate s to [20'h80000, 20'h7FFFF] and write z[i].
- After i=1 cycle B, go to DONE and set `EnableReadParametric`=1.
- DONE:
  - Holds `EnableReadParametric`=1 and keeps serving reads.
  - A new rising edge of `Encoder_done` clears `EnableReadParametric` in the same edge and re-enters FETCH.
- A rising edge of `Encoder_done` during FETCH or COMPUTE is ignored.
- Decoder reads are served in every state. z keeps its last value until it is overwritten in COMPUTE.

## Timing
- Let edge 0 be the edge that samples the `Encoder_done` rise.
- `Encoder_output_address` = 0,1,2,3 after edges 0,1,2,3.
- Captures occur at edges 2..5.
- z0 is written at edge 7 and z1 at edge 9.
- `EnableReadParametric` goes high at edge 9, so the first read is valid the cycle after.
- Read latency is 1 cycle: address at edge n gives data after edge n+1.
- Reset, asynchronous, whenever asserted, including mid-run:
  - state = IDLE.
  - `EnableReadParametric`=0, `Parametric_data`=0 and `Encoder_output_address`=0.
  - mu, lv, z and the edge detector are cleared to 0.
  - LFSR = `LFSR_SEED`.
- Reset release is synchronous to `clk`. The first rising edge of `Encoder_done` after release starts a run.

## Configuration
- `REPARAM_LFSR_EN` defined:
  - eps comes from a 16-bit Fibonacci LFSR with taps 16,14,13,11.
  - eps = sign-extend(lfsr[15:4]), Q2.10, range [-2,2).
  - Latent i uses the current LFSR state in its cycle A. The LFSR advances once at the end of that cycle, giving 2 steps per run.
- Not defined:
  - eps = 0 and no LFSR exists.
  - z = mu exactly; this is deterministic inference mode.

## Test plan
- Macro off; mu=(20'h00400, 20'hFFE00), lv=(0,0) → after `EnableReadParametric`, reads of addresses 0/1/2 return 20'h00400 / 20'hFFE00 / 0.
- Macro on, seed 16'hACE1; mu0=0, lv0=0 → sigma=1024, eps0=20'hFFACE → z0=20'hFFACE.
- Macro on, seed default; mu0=20'h80400 (-511.0), lv0=20'h05000 (+20.0) → k clamps to 9 and z0 saturates to 20'h80000.
- Timing: pulse `Encoder_done` → address sequence 0,1,2,3 on edges 0..3 and `EnableReadParametric` rises exactly at edge 9; a second `Encoder_done` rise at edge 4 is ignored.
- Assert `reset` at edge 6 of a run → all outputs 0 immediately. After release, a new `Encoder_done` rise completes normally with fresh values.
- In DONE, raise `Encoder_done` again with new mu → `EnableReadParametric` drops at that edge, rises 9 edges later, and reads return the new z.

Source files
------------

// File: rtl/reparameterization_sampler_if.sv
// ---------------------------------------------------------------------------
// reparameterization_sampler_if
// Groups the encoder fetch port and the decoder parametric-read port of the
// reparameterization sampler.
//   master : the sampler (drives encoder address, parametric data, enable)
//   slave  : the environment (encoder buffer + decoder)
// Signals:
//   Encoder_done            level, rising edge starts a run
//   Encoder_output_address  2-bit encoder read address (0/1 mu, 2/3 logvar)
//   Encoder_output_data     W-bit signed Q10.10, valid one cycle after address
//   Reparam_output_address  2-bit decoder read address
//   Parametric_data         W-bit registered read data
//   EnableReadParametric    high while z is valid
// ---------------------------------------------------------------------------
interface reparameterization_sampler_if #(
    parameter int W = 20
);
    logic         Encoder_done;
    logic [1:0]   Encoder_output_address;
    logic [W-1:0] Encoder_output_data;
    logic [1:0]   Reparam_output_address;
    logic [W-1:0] Parametric_data;
    logic         EnableReadParametric;

    modport master (
        input  Encoder_done,
        input  Encoder_output_data,
        input  Reparam_output_address,
        output Encoder_output_address,
        output Parametric_data,
        output EnableReadParametric
    );

    modport slave (
        output Encoder_done,
        output Encoder_output_data,
        output Reparam_output_address,
        input  Encoder_output_address,
        input  Parametric_data,
        input  EnableReadParametric
    );
endinterface

// File: rtl/reparameterization_sampler.sv
// ---------------------------------------------------------------------------
// reparameterization_sampler
// Computes the 2-entry VAE latent z = mu + exp(0.5*logvar)*eps in signed
// Q10.10, fetching mu/logvar from the encoder buffer and serving registered
// reads of z to the decoder.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : reparameterization_sampler_if.master (encoder fetch + decoder read)
// Optional feature macro: REPARAM_LFSR_EN
//   defined   -> eps is drawn from a 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   undefined -> eps = 0, z = mu exactly (deterministic inference)
// ---------------------------------------------------------------------------
module reparameterization_sampler #(
    parameter int          LATENT         = 2,
    parameter int          integer_width  = 10,
    parameter int          fraction_width = 10,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    reparameterization_sampler_if.master  bus
);
    localparam int W  = integer_width + fraction_width;
    localparam int PW = 2 * W + 2;  // sigma (W+1 bits, unsigned) times eps, signed

    localparam logic signed [PW-1:0] Z_MAX_C = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] Z_MIN_C = -Z_MAX_C - PW'(64'sd1);

    // Only two latents are indexed, and an all-zero seed would lock the LFSR.
    if (LATENT != 2 || LFSR_SEED == 16'h0000) begin : g_unsupported_config
        $error("reparameterization_sampler: unsupported LATENT or zero LFSR_SEED");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  done_prev_q;
    logic                  rise_s;
    logic [1:0]            addr_q, addr_d;
    logic [W-1:0]          rd_q, rd_d;
    logic                  en_q, en_d;
    logic signed [W-1:0]   mu_q [LATENT];
    logic signed [W-1:0]   mu_d [LATENT];
    logic signed [W-1:0]   lv_q [LATENT];
    logic signed [W-1:0]   lv_d [LATENT];
    logic signed [W-1:0]   z_q  [LATENT];
    logic signed [W-1:0]   z_d  [LATENT];
    logic [W:0]            sigma_q, sigma_d, sigma_s;
    logic signed [W-1:0]   eps_s;
    logic                  lat_s;
    logic signed [W-1:0]   y_s;
    logic signed [31:0]    yprod_s, t_s, kraw_s;
    logic signed [4:0]     kc_s;
    logic [10:0]           base_s;
    logic signed [PW-1:0]  sig_ext_s, eps_ext_s, prod_s, p_s, mu_ext_s, sum_s;
    logic signed [W-1:0]   zsat_s;

`ifdef REPARAM_LFSR_EN
    logic [15:0]           lfsr_q, lfsr_d;
    logic signed [W-1:0]   eps_q, eps_d;

    // Fibonacci step, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    assign eps_s = eps_q;
`else
    assign eps_s = {W{1'b0}};
`endif

    assign rise_s = bus.Encoder_done & ~done_prev_q;
    // Counter bit 1 selects the latent element during COMPUTE, bit 0 the A/B phase.
    assign lat_s  = cnt_q[1];

    assign bus.Encoder_output_address = addr_q;
    assign bus.Parametric_data        = rd_q;
    assign bus.EnableReadParametric   = en_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Encoder_done rises are only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise_s) state_d = FETCH;
                else        state_d = IDLE;
            end
            FETCH: begin
                if (cnt_q == 3'd4) state_d = COMPUTE;
                else               state_d = FETCH;
            end
            COMPUTE: begin
                if (cnt_q == 3'd3) state_d = DONE;
                else               state_d = COMPUTE;
            end
            DONE: begin
                if (rise_s) state_d = FETCH;
                else        state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Cycle A: sigma = 2^(0.5*lv*log2(e)) via Mitchell approximation.
    always_comb begin
        y_s     = lv_q[lat_s] >>> 1;
        yprod_s = 32'(y_s) * 32'sd1477;
        t_s     = yprod_s >>> fraction_width;
        kraw_s  = t_s >>> fraction_width;
        base_s  = {1'b1, t_s[9:0]};
        if (kraw_s > 32'sd9) begin
            kc_s = 5'sd9;
        end else if (kraw_s < -32'sd10) begin
            kc_s = -5'sd10;
        end else begin
            kc_s = kraw_s[4:0];
        end
        if (kc_s >= 5'sd0) begin
            sigma_s = {{(W - 10){1'b0}}, base_s} << $unsigned(kc_s);
        end else begin
            sigma_s = {{(W - 10){1'b0}}, base_s} >> $unsigned(5'sd0 - kc_s);
        end
    end

    // Cycle B: z = sat(mu + (sigma*eps)>>>10).
    always_comb begin
        sig_ext_s = $signed({{(PW - W - 1){1'b0}}, sigma_q});
        eps_ext_s = PW'(eps_s);
        prod_s    = sig_ext_s * eps_ext_s;
        p_s       = prod_s >>> fraction_width;
        mu_ext_s  = PW'(mu_q[lat_s]);
        sum_s     = mu_ext_s + p_s;
        if (sum_s > Z_MAX_C) begin
            zsat_s = {1'b0, {(W - 1){1'b1}}};
        end else if (sum_s < Z_MIN_C) begin
            zsat_s = {1'b1, {(W - 1){1'b0}}};
        end else begin
            zsat_s = sum_s[W-1:0];
        end
    end

    // FSM outputs: fetch addressing/capture, compute writes, read port and enable.
    always_comb begin
        addr_d  = addr_q;
        mu_d    = mu_q;
        lv_d    = lv_q;
        z_d     = z_q;
        sigma_d = sigma_q;
`ifdef REPARAM_LFSR_EN
        lfsr_d  = lfsr_q;
        eps_d   = eps_q;
`endif
        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end else if (state_q == FETCH || state_q == COMPUTE) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = 3'd0;
        end
        case (state_q)
            IDLE, DONE: begin
                if (rise_s) addr_d = 2'd0;
                else        addr_d = addr_q;
            end
            FETCH: begin
                if (cnt_q < 3'd3) addr_d = cnt_q[1:0] + 2'd1;
                else              addr_d = addr_q;
                // Data for the address issued at count c arrives at count c+1.
                case (cnt_q)
                    3'd1:    mu_d[0] = bus.Encoder_output_data;
                    3'd2:    mu_d[1] = bus.Encoder_output_data;
                    3'd3:    lv_d[0] = bus.Encoder_output_data;
                    3'd4:    lv_d[1] = bus.Encoder_output_data;
                    default: mu_d    = mu_q;
                endcase
            end
            COMPUTE: begin
                if (!cnt_q[0]) begin
                    sigma_d = sigma_s;
`ifdef REPARAM_LFSR_EN
                    eps_d   = {{(W - 12){lfsr_q[15]}}, lfsr_q[15:4]};
                    lfsr_d  = lfsr_step(lfsr_q);
`endif
                end else begin
                    z_d[lat_s] = zsat_s;
                end
            end
            default: addr_d = addr_q;
        endcase
        if (bus.Reparam_output_address[1]) rd_d = {W{1'b0}};
        else                               rd_d = z_q[bus.Reparam_output_address[0]];
        en_d = (state_d == DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= 3'd0;
            done_prev_q <= 1'b0;
            addr_q      <= 2'd0;
            rd_q        <= {W{1'b0}};
            en_q        <= 1'b0;
            mu_q        <= '{default: '0};
            lv_q        <= '{default: '0};
            z_q         <= '{default: '0};
            sigma_q     <= {(W + 1){1'b0}};
`ifdef REPARAM_LFSR_EN
            lfsr_q      <= LFSR_SEED;
            eps_q       <= {W{1'b0}};
`endif
        end else begin
            cnt_q       <= cnt_d;
            done_prev_q <= bus.Encoder_done;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            en_q        <= en_d;
            mu_q        <= mu_d;
            lv_q        <= lv_d;
            z_q         <= z_d;
            sigma_q     <= sigma_d;
`ifdef REPARAM_LFSR_EN
            lfsr_q      <= lfsr_d;
            eps_q       <= eps_d;
`endif
        end
    end
endmodule

// File: tb/tb_reparameterization_sampler.sv
module tb_reparameterization_sampler;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [19:0] enc_mem [4];
    logic [19:0] z_m [2];
    logic [15:0] lfsr_m;

    reparameterization_sampler_if #(.W(20)) sif ();

    reparameterization_sampler #(
        .LATENT(2), .integer_width(10), .fraction_width(10), .LFSR_SEED(SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    // Encoder output buffer: registered read, data valid one cycle after address.
    always @(posedge clk) sif.Encoder_output_data <= enc_mem[sif.Encoder_output_address];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // z = mu + exp(lv/2)*eps with the 2^t Mitchell approximation, plain integer math.
    function automatic logic [19:0] ref_z(input logic [19:0] mu, input logic [19:0] lv,
                                          input longint eps);
        longint lv_v, mu_v, y, t, k, f, sig, s;
        lv_v = longint'($signed(lv));
        mu_v = longint'($signed(mu));
        y    = lv_v >>> 1;
        t    = (y * 1477) >>> 10;
        f    = t & 1023;
        k    = t >>> 10;
        if (k > 9) k = 9;
        if (k < -10) k = -10;
        if (k >= 0) sig = (1024 + f) * (longint'(1) << k);
        else        sig = (1024 + f) / (longint'(1) << (-k));
        s = mu_v + ((sig * eps) >>> 10);
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
        return 20'(s);
    endfunction

    function automatic longint next_eps();
        longint e;
        e = 0;
`ifdef REPARAM_LFSR_EN
        e = longint'($signed(lfsr_m[15:4]));
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
        return e;
    endfunction

    task automatic read_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            sif.Reparam_output_address = 2'(a);
            tick();
            check_eq($sformatf("%s_rd%0d", tag, a), 32'(sif.Parametric_data),
                     (a < 2) ? 32'(z_m[a]) : 32'd0);
        end
    endtask

    // One complete run; a spurious Encoder_done rise is injected at edge 4.
    task automatic run_pass(input string tag, input logic [19:0] mu0, input logic [19:0] mu1,
                            input logic [19:0] lv0, input logic [19:0] lv1);
        longint e0, e1;
        enc_mem[0] = mu0; enc_mem[1] = mu1; enc_mem[2] = lv0; enc_mem[3] = lv1;
        e0 = next_eps();
        e1 = next_eps();
        sif.Encoder_done = 1'b0;
        tick();
        sif.Encoder_done = 1'b1;
        tick();  // edge 0
        check_eq($sformatf("%s_en_e0", tag), 32'(sif.EnableReadParametric), 32'd0);
        check_eq($sformatf("%s_addr0", tag), 32'(sif.Encoder_output_address), 32'd0);
        sif.Encoder_done = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_eq($sformatf("%s_addr%0d", tag, e), 32'(sif.Encoder_output_address), 32'(e));
        end
        sif.Encoder_done = 1'b1;
        for (int e = 4; e <= 8; e++) tick();
        check_eq($sformatf("%s_en_e8", tag), 32'(sif.EnableReadParametric), 32'd0);
        tick();  // edge 9
        check_eq($sformatf("%s_en_e9", tag), 32'(sif.EnableReadParametric), 32'd1);
        z_m[0] = ref_z(mu0, lv0, e0);
        z_m[1] = ref_z(mu1, lv1, e1);
        read_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        sif.Encoder_done = 1'b0;
        sif.Reparam_output_address = 2'd0;
        for (int i = 0; i < 4; i++) enc_mem[i] = 20'h00000;
        z_m[0] = 20'h00000;
        z_m[1] = 20'h00000;
        lfsr_m = SEED;
        #2;
        check_eq("rst_en", 32'(sif.EnableReadParametric), 32'd0);
        check_eq("rst_data", 32'(sif.Parametric_data), 32'd0);
        check_eq("rst_addr", 32'(sif.Encoder_output_address), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_pass("seed_eps", 20'h00000, 20'h00123, 20'h00000, 20'h00400);
        run_pass("det", 20'h00400, 20'hFFE00, 20'h00000, 20'h00000);
        run_pass("sat_lo", 20'h80400, 20'h7FC00, 20'h05000, 20'h05000);
        run_pass("extremes", 20'h80000, 20'h7FFFF, 20'hF6000, 20'h7FFFF);
        for (int r = 0; r < 6; r++) begin
            logic [19:0] m0, m1, l0, l1;
            m0 = 20'($urandom);
            m1 = 20'($urandom);
            l0 = (r < 3) ? 20'($signed(12'($urandom))) : 20'($urandom);
            l1 = (r < 3) ? 20'($signed(12'($urandom))) : 20'($urandom);
            run_pass($sformatf("rnd%0d", r), m0, m1, l0, l1);
        end

        // Mid-run reset at edge 6: outputs clear at once, z and LFSR restart.
        run_pass("pre_rst", 20'h01234, 20'h05678, 20'h00000, 20'h00000);
        sif.Reparam_output_address = 2'd0;
        enc_mem[0] = 20'h03333;
        sif.Encoder_done = 1'b0;
        tick();
        sif.Encoder_done = 1'b1;
        tick();  // edge 0
        sif.Encoder_done = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check_eq("mid_data_live", 32'(sif.Parametric_data), 32'(z_m[0]));
        reset = 1'b0;
        #1;
        check_eq("mid_rst_en", 32'(sif.EnableReadParametric), 32'd0);
        check_eq("mid_rst_data", 32'(sif.Parametric_data), 32'd0);
        check_eq("mid_rst_addr", 32'(sif.Encoder_output_address), 32'd0);
        z_m[0] = 20'h00000;
        z_m[1] = 20'h00000;
        lfsr_m = SEED;
        tick();
        tick();
        reset = 1'b1;
        tick();
        read_all("post_rst_z");
        run_pass("after_rst", 20'hFF000, 20'h00ABC, 20'h00000, 20'hFFC00);
        run_pass("final", 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
